// File: rtl/spi_regfile_periph_pkg.sv
// Shared types and helpers for the SPI register-file peripheral.
// Holds the frame FSM states, the R/W bit encodings and the frame-length derivation.
package spi_regfile_periph_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ADDR = 2'd1,
    ST_DATA = 2'd2,
    ST_DONE = 2'd3
  } state_e;

  localparam logic RW_WRITE = 1'b1;
  localparam logic RW_READ  = 1'b0;

  // One R/W bit, then the address field, then the data field.
  function automatic int frame_w(input int addr_w, input int data_w);
    return 1 + addr_w + data_w;
  endfunction

endpackage

// File: rtl/spi_sync_edge.sv
// Two-flop synchroniser for one asynchronous input.
// Also gives single-clk rise/fall pulses derived from the synchronised value.
module spi_sync_edge
  import spi_regfile_periph_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic d_i,
  output logic q_o,
  output logic rise_o,
  output logic fall_o
);

  logic meta_q;
  logic sync_q;
  logic prev_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
      prev_q <= 1'b0;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
      prev_q <= sync_q;
    end
  end

  assign q_o    = sync_q;
  assign rise_o = sync_q & ~prev_q;
  assign fall_o = ~sync_q & prev_q;

endmodule

// File: rtl/spi_regfile_periph.sv
// SPI mode-0 peripheral exposing NUM_REGS writable registers.
// Frame: R/W bit, address, data (all MSB first); writes commit on nCS rise.
module spi_regfile_periph
  import spi_regfile_periph_pkg::*;
#(
  parameter int NUM_REGS = 8,
  parameter int ADDR_W   = 7,
  parameter int DATA_W   = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       SCLK,
  input  logic                       nCS,
  input  logic                       COPI,
  output logic                       CIPO,
  output logic                       cipo_oe,
  output logic [NUM_REGS*DATA_W-1:0] regs_q,
  output logic                       wr_stb,
  output logic [ADDR_W-1:0]          wr_addr,
  output logic                       frame_err
);

  localparam int FRAME_W = frame_w(ADDR_W, DATA_W);
  localparam int CNT_W   = $clog2(FRAME_W + 2);
  localparam logic [CNT_W-1:0] CNT_ADDR_END = CNT_W'(1 + ADDR_W);
  localparam logic [CNT_W-1:0] CNT_FRAME    = CNT_W'(FRAME_W);
  localparam logic [CNT_W-1:0] CNT_OVER     = CNT_W'(FRAME_W + 1);

  logic sclk_s, sclk_rise, sclk_fall;
  logic ncs_s, ncs_rise, ncs_fall;
  logic copi_s, copi_rise, copi_fall;
  logic unused_sync;

  spi_sync_edge u_sync_sclk (
    .clk(clk), .rst(rst), .d_i(SCLK), .q_o(sclk_s), .rise_o(sclk_rise), .fall_o(sclk_fall)
  );
  spi_sync_edge u_sync_ncs (
    .clk(clk), .rst(rst), .d_i(nCS), .q_o(ncs_s), .rise_o(ncs_rise), .fall_o(ncs_fall)
  );
  spi_sync_edge u_sync_copi (
    .clk(clk), .rst(rst), .d_i(COPI), .q_o(copi_s), .rise_o(copi_rise), .fall_o(copi_fall)
  );

  assign unused_sync = ^{sclk_s, copi_rise, copi_fall};

  state_e              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d, cnt_inc;
  logic [FRAME_W-1:0]  sr_q, sr_d, sr_shift;
  logic [DATA_W-1:0]   osr_q, osr_d;
  logic                cipo_q, cipo_d;
  logic                ovl_q, ovl_d;
  logic                wr_stb_q, wr_stb_d;
  logic                frame_err_q, frame_err_d;
  logic [ADDR_W-1:0]   wr_addr_q, wr_addr_d;
  logic [DATA_W-1:0]   rf_q [NUM_REGS];
  logic [DATA_W-1:0]   rf_d [NUM_REGS];

  logic [DATA_W-1:0]   rd_data;
  logic                fr_rw;
  logic [ADDR_W-1:0]   fr_addr;
  logic [DATA_W-1:0]   fr_data;
  logic                addr_hit;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    sr_d        = sr_q;
    osr_d       = osr_q;
    cipo_d      = cipo_q;
    ovl_d       = ovl_q;
    wr_stb_d    = 1'b0;
    frame_err_d = 1'b0;
    wr_addr_d   = wr_addr_q;
    rf_d        = rf_q;

    cnt_inc  = cnt_q + CNT_W'(1);
    sr_shift = {sr_q[FRAME_W-2:0], copi_s};
    fr_rw    = sr_q[FRAME_W-1];
    fr_addr  = sr_q[DATA_W +: ADDR_W];
    fr_data  = sr_q[DATA_W-1:0];

    // Read mux sees the address as it will be once the current bit lands.
    rd_data  = '0;
    addr_hit = 1'b0;
    for (int k = 0; k < NUM_REGS; k++) begin
      if (sr_shift[ADDR_W-1:0] == ADDR_W'(k)) rd_data = rf_q[k];
      if (fr_addr == ADDR_W'(k)) addr_hit = 1'b1;
    end

    if (ncs_fall) begin
      state_d = ST_ADDR;
      cnt_d   = '0;
      sr_d    = '0;
      osr_d   = '0;
      cipo_d  = 1'b0;
      ovl_d   = 1'b0;
    end else if (ncs_rise) begin
      state_d = ST_IDLE;
      cipo_d  = 1'b0;
      if (state_q != ST_IDLE) begin
        if (cnt_q != CNT_FRAME || ovl_q) begin
          frame_err_d = 1'b1;
        end else if (fr_rw == RW_WRITE && addr_hit) begin
          wr_stb_d  = 1'b1;
          wr_addr_d = fr_addr;
          for (int k = 0; k < NUM_REGS; k++) begin
            if (fr_addr == ADDR_W'(k)) rf_d[k] = fr_data;
          end
        end
      end
    end else if (!ncs_s) begin
      if (sclk_rise) begin
        case (state_q)
          ST_ADDR: begin
            sr_d  = sr_shift;
            cnt_d = cnt_inc;
            if (cnt_inc == CNT_ADDR_END) begin
              state_d = ST_DATA;
              osr_d   = (sr_shift[ADDR_W] == RW_READ) ? rd_data : '0;
            end
          end
          ST_DATA: begin
            sr_d  = sr_shift;
            cnt_d = cnt_inc;
            if (cnt_inc == CNT_FRAME) state_d = ST_DONE;
          end
          ST_DONE: begin
            ovl_d = 1'b1;
            cnt_d = CNT_OVER;
          end
          default: ;
        endcase
      end else if (sclk_fall && state_q == ST_DATA) begin
        cipo_d = osr_q[DATA_W-1];
        osr_d  = osr_q << 1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      sr_q        <= '0;
      osr_q       <= '0;
      cipo_q      <= 1'b0;
      ovl_q       <= 1'b0;
      wr_stb_q    <= 1'b0;
      frame_err_q <= 1'b0;
      wr_addr_q   <= '0;
      for (int k = 0; k < NUM_REGS; k++) rf_q[k] <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      sr_q        <= sr_d;
      osr_q       <= osr_d;
      cipo_q      <= cipo_d;
      ovl_q       <= ovl_d;
      wr_stb_q    <= wr_stb_d;
      frame_err_q <= frame_err_d;
      wr_addr_q   <= wr_addr_d;
      rf_q        <= rf_d;
    end
  end

  for (genvar g = 0; g < NUM_REGS; g++) begin : g_flat
    assign regs_q[g*DATA_W +: DATA_W] = rf_q[g];
  end

  assign CIPO      = cipo_q & (state_q == ST_DATA);
  assign cipo_oe   = (state_q != ST_IDLE);
  assign wr_stb    = wr_stb_q;
  assign wr_addr   = wr_addr_q;
  assign frame_err = frame_err_q;

endmodule

// File: tb/tb_spi_regfile_periph.sv
// Directed bench for spi_regfile_periph: default instance plus a 4x16-bit instance.
module tb_spi_regfile_periph;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        SCLK = 1'b0;
  logic        COPI = 1'b0;
  logic        nCS_a = 1'b1;
  logic        nCS_b = 1'b1;

  logic        CIPO_a, cipo_oe_a, wr_stb_a, frame_err_a;
  logic [63:0] regs_a;
  logic [6:0]  wr_addr_a;
  logic        CIPO_b, cipo_oe_b, wr_stb_b, frame_err_b;
  logic [63:0] regs_b;
  logic [2:0]  wr_addr_b;

  always #5 clk = ~clk;

  spi_regfile_periph u_dut_a (
    .clk(clk), .rst(rst), .SCLK(SCLK), .nCS(nCS_a), .COPI(COPI),
    .CIPO(CIPO_a), .cipo_oe(cipo_oe_a), .regs_q(regs_a),
    .wr_stb(wr_stb_a), .wr_addr(wr_addr_a), .frame_err(frame_err_a)
  );

  spi_regfile_periph #(.NUM_REGS(4), .ADDR_W(3), .DATA_W(16)) u_dut_b (
    .clk(clk), .rst(rst), .SCLK(SCLK), .nCS(nCS_b), .COPI(COPI),
    .CIPO(CIPO_b), .cipo_oe(cipo_oe_b), .regs_q(regs_b),
    .wr_stb(wr_stb_b), .wr_addr(wr_addr_b), .frame_err(frame_err_b)
  );

  typedef struct packed {
    logic [6:0] addr;
    logic [7:0] data;
  } wr_exp_t;

  wr_exp_t exp_wr_q[$];
  logic [7:0] exp_rd_q[$];

  int n_checks = 0;
  int n_pass   = 0;
  int stb_cnt_a = 0, ferr_cnt_a = 0;
  int stb_cnt_b = 0, ferr_cnt_b = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  // Scoreboard side: every committed write on DUT A is matched against the queue.
  always @(negedge clk) begin
    wr_exp_t e;
    if (wr_stb_a) begin
      stb_cnt_a++;
      if (exp_wr_q.size() == 0) begin
        check("unexpected_wr_stb", 64'(wr_stb_a), 64'd0);
      end else begin
        e = exp_wr_q.pop_front();
        check("wr_addr", 64'(wr_addr_a), 64'(e.addr));
        check("wr_reg_value", 64'(regs_a[int'(wr_addr_a)*8 +: 8]), 64'(e.data));
      end
    end
    if (frame_err_a) ferr_cnt_a++;
    if (wr_stb_b) stb_cnt_b++;
    if (frame_err_b) ferr_cnt_b++;
  end

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic set_ncs(input bit sel, input logic v);
    if (sel) nCS_b = v;
    else     nCS_a = v;
  endtask

  task automatic spi_bits(input bit sel, input int nbits, input logic [31:0] val,
                          output logic [31:0] rx);
    logic [31:0] acc;
    acc = '0;
    for (int i = nbits - 1; i >= 0; i--) begin
      COPI = val[i];
      wait_clk(4);
      acc  = {acc[30:0], (sel ? CIPO_b : CIPO_a)};
      SCLK = 1'b1;
      wait_clk(4);
      SCLK = 1'b0;
    end
    rx = acc;
  endtask

  task automatic spi_xfer(input bit sel, input int nbits, input logic [31:0] val,
                          output logic [31:0] rx);
    set_ncs(sel, 1'b0);
    wait_clk(6);
    spi_bits(sel, nbits, val, rx);
    wait_clk(4);
    set_ncs(sel, 1'b1);
    wait_clk(6);
  endtask

  initial begin
    logic [31:0] rx;
    logic [7:0]  rd_exp;

    // Reset state
    wait_clk(4);
    check("rst_CIPO", 64'(CIPO_a), 64'd0);
    check("rst_cipo_oe", 64'(cipo_oe_a), 64'd0);
    check("rst_wr_stb", 64'(wr_stb_a), 64'd0);
    check("rst_frame_err", 64'(frame_err_a), 64'd0);
    check("rst_wr_addr", 64'(wr_addr_a), 64'd0);
    check("rst_regs_a", regs_a, 64'd0);
    check("rst_regs_b", regs_b, 64'd0);
    rst = 1'b0;
    wait_clk(6);

    // Write 0x04 <- 0xA5
    exp_wr_q.push_back('{addr: 7'h04, data: 8'hA5});
    spi_xfer(1'b0, 16, 32'h84A5, rx);
    check("w4_queue_drained", 64'(exp_wr_q.size()), 64'd0);
    check("w4_regs", regs_a, 64'h000000A5_00000000);
    check("w4_stb_count", 64'(stb_cnt_a), 64'd1);
    check("w4_wr_addr_held", 64'(wr_addr_a), 64'd4);

    // Read address 4: CIPO low during address phase, then A5 MSB first
    exp_rd_q.push_back(8'hA5);
    spi_xfer(1'b0, 16, 32'h0400, rx);
    rd_exp = exp_rd_q.pop_front();
    check("r4_data_bits", 64'(rx[7:0]), 64'(rd_exp));
    check("r4_addr_phase_cipo", 64'(rx[15:8]), 64'd0);
    check("r4_regs_unchanged", regs_a, 64'h000000A5_00000000);
    check("r4_no_stb", 64'(stb_cnt_a), 64'd1);
    check("r4_cipo_oe_idle", 64'(cipo_oe_a), 64'd0);

    // Out-of-range write and read
    spi_xfer(1'b0, 16, 32'hFFFF, rx);
    check("w7f_regs", regs_a, 64'h000000A5_00000000);
    check("w7f_no_stb", 64'(stb_cnt_a), 64'd1);
    check("w7f_no_ferr", 64'(ferr_cnt_a), 64'd0);
    exp_rd_q.push_back(8'h00);
    spi_xfer(1'b0, 16, 32'h7F00, rx);
    rd_exp = exp_rd_q.pop_front();
    check("r7f_data", 64'(rx[7:0]), 64'(rd_exp));

    // Short and long frames to address 0
    spi_xfer(1'b0, 15, 32'h805A >> 1, rx);
    check("short_ferr", 64'(ferr_cnt_a), 64'd1);
    check("short_regs", regs_a, 64'h000000A5_00000000);
    spi_xfer(1'b0, 17, 32'h100B5, rx);
    check("long_ferr", 64'(ferr_cnt_a), 64'd2);
    check("long_regs", regs_a, 64'h000000A5_00000000);
    check("short_long_no_stb", 64'(stb_cnt_a), 64'd1);

    // SCLK activity with nCS high is ignored
    for (int i = 0; i < 6; i++) begin
      COPI = 1'b1; SCLK = 1'b1; wait_clk(4);
      SCLK = 1'b0; wait_clk(4);
    end
    check("idle_sclk_no_ferr", 64'(ferr_cnt_a), 64'd2);
    check("idle_sclk_regs", regs_a, 64'h000000A5_00000000);

    // Reset after 10 bits of a write to address 2
    nCS_a = 1'b0;
    wait_clk(6);
    spi_bits(1'b0, 10, 32'h82FF >> 6, rx);
    check("mid_cipo_oe", 64'(cipo_oe_a), 64'd1);
    rst = 1'b1;
    wait_clk(3);
    check("midrst_regs", regs_a, 64'd0);
    check("midrst_outs", 64'({CIPO_a, cipo_oe_a, wr_stb_a, frame_err_a}), 64'd0);
    check("midrst_wr_addr", 64'(wr_addr_a), 64'd0);
    rst = 1'b0;
    wait_clk(2);
    spi_bits(1'b0, 6, 32'h3F, rx);
    wait_clk(4);
    nCS_a = 1'b1;
    wait_clk(6);
    check("abort_no_commit", regs_a, 64'd0);
    check("abort_no_ferr", 64'(ferr_cnt_a), 64'd2);
    exp_wr_q.push_back('{addr: 7'h01, data: 8'h3C});
    spi_xfer(1'b0, 16, 32'h813C, rx);
    check("w1_queue_drained", 64'(exp_wr_q.size()), 64'd0);
    check("w1_regs", regs_a, 64'h00000000_00003C00);

    // Back-to-back writes with a short nCS-high gap
    exp_wr_q.push_back('{addr: 7'h07, data: 8'h11});
    exp_wr_q.push_back('{addr: 7'h00, data: 8'h22});
    nCS_a = 1'b0; wait_clk(6);
    spi_bits(1'b0, 16, 32'h8711, rx);
    wait_clk(2); nCS_a = 1'b1; wait_clk(4);
    nCS_a = 1'b0; wait_clk(6);
    spi_bits(1'b0, 16, 32'h8022, rx);
    wait_clk(2); nCS_a = 1'b1; wait_clk(6);
    check("b2b_queue_drained", 64'(exp_wr_q.size()), 64'd0);
    check("b2b_regs", regs_a, 64'h11000000_00003C22);

    // Wide instance: 20-bit write 0x2 <- 0xBEEF
    spi_xfer(1'b1, 20, 32'hABEEF, rx);
    check("b_reg2", 64'(regs_b[47:32]), 64'hBEEF);
    check("b_regs_all", regs_b, 64'h0000BEEF_00000000);
    check("b_stb_count", 64'(stb_cnt_b), 64'd1);
    check("b_wr_addr", 64'(wr_addr_b), 64'd2);
    check("b_no_ferr", 64'(ferr_cnt_b), 64'd0);
    check("a_untouched_by_b", regs_a, 64'h11000000_00003C22);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/spi_regfile_periph.md
SPI_REGFILE_PERIPH -- requirements
Module: spi_regfile_periph

Interface
REQ-001 SHALL have parameter NUM_REGS, default 8: number of writable registers, 1..2**ADDR_W.
REQ-002 SHALL have parameter ADDR_W, default 7: address field width in bits.
REQ-003 SHALL have parameter DATA_W, default 8: register and data field width in bits; frame length FRAME_W = 1+ADDR_W+DATA_W (16 at defaults).
REQ-004 SHALL have port clk, input, 1: the single system clock; all state is in this clock domain.
REQ-005 SHALL have port rst, input, 1: reset, synchronous and active-high.
REQ-006 SHALL have port SCLK, input, 1: SPI clock, asynchronous to clk, mode 0 (CPOL=0, CPHA=0).
REQ-007 SHALL have port nCS, input, 1: SPI chip select, active-low, asynchronous.
REQ-008 SHALL have port COPI, input, 1: controller-out data, MSB first.
REQ-009 SHALL have port CIPO, output, 1: peripheral-out data, MSB first.
REQ-010 SHALL have port cipo_oe, output, 1: CIPO output enable, high only while nCS (synchronised) is low.
REQ-011 SHALL have port regs_q, output, NUM_REGS*DATA_W: all register contents; register k occupies bits [k*DATA_W +: DATA_W].
REQ-012 SHALL have port wr_stb, output, 1: one-clk pulse on each committed write.
REQ-013 SHALL have port wr_addr, output, ADDR_W: address of the most recent committed write; holds its value between writes.
REQ-014 SHALL have port frame_err, output, 1: one-clk pulse when a frame is discarded.

Function
REQ-015 SCLK, nCS and COPI SHALL each pass a 2-flop synchroniser; edges are detected on synchronised values only; at most 3 clk of input latency.
REQ-016 Frame layout SHALL be: bit 0 = R/W (1 = write, 0 = read), then ADDR_W address bits, then DATA_W data bits, each field MSB first.
REQ-017 FSM states SHALL be IDLE, ADDR, DATA and DONE; nCS falling moves IDLE->ADDR and clears the bit counter and the shift register.
REQ-018 On each synchronised SCLK rise while nCS is low, the block SHALL shift in COPI and increment the bit counter; ADDR->DATA after bit 1+ADDR_W; DATA->DONE after bit FRAME_W.
REQ-019 Any SCLK rise in DONE SHALL mark the frame overlong; the counter saturates and does not wrap.
REQ-020 On nCS rise, a write frame with exactly FRAME_W bits and address < NUM_REGS SHALL update that register 1 clk later and pulse wr_stb together with wr_addr.
REQ-021 A write frame with address >= NUM_REGS SHALL be ignored silently: no register change, no wr_stb, no frame_err.
REQ-022 On nCS rise with bit count != FRAME_W, the frame SHALL be discarded with no register change and a frame_err pulse; the FSM returns to IDLE.
REQ-023 Read: on the SCLK rise capturing the last address bit, the block SHALL load the addressed register (0 if address >= NUM_REGS) into the output shifter.
REQ-024 Each synchronised SCLK fall in DATA SHALL present the next output bit on CIPO, starting with the MSB; CIPO SHALL be 0 in IDLE, ADDR and DONE.
REQ-025 A read frame SHALL never modify registers or pulse wr_stb.
REQ-026 If nCS and SCLK edges are detected in the same clk, the nCS edge SHALL take priority and the SCLK edge is dropped.
REQ-027 SCLK edges while nCS is high SHALL be ignored.
REQ-028 Back-to-back frames with an nCS-high gap of at least 3 clk SHALL both be handled correctly.

Reset
REQ-029 While rst is high, all registers, shift registers, counters and synchroniser flops SHALL clear to 0; FSM -> IDLE; CIPO = 0, cipo_oe = 0, wr_stb = 0, frame_err = 0, wr_addr = 0.
REQ-030 Reset asserted mid-frame SHALL abort the frame with no commit; after release, the block SHALL wait for a fresh nCS fall.

Structure
REQ-031 A shared package SHALL hold the FSM state enum, the R/W bit encodings and the FRAME_W derivation function.
REQ-032 One sub-module, spi_sync_edge, SHALL provide a 2-flop synchroniser plus rise/fall pulses, instantiated three times.
REQ-033 The register file SHALL be an array indexed by address with a generate-built regs_q flattening.

Verification
REQ-034 Write 0x04 <- 0xA5 at defaults -> register 4 = 0xA5 and wr_stb pulses once with wr_addr = 4; all other registers stay 0.
REQ-035 After REQ-034, read address 4 -> CIPO shifts 1,0,1,0,0,1,0,1 over the 8 data SCLK falls; registers unchanged.
REQ-036 Write 0x7F <- 0xFF -> no register change, no wr_stb, no frame_err; read 0x7F -> returns 0x00.
REQ-037 15-bit and 17-bit write frames to address 0 -> register 0 unchanged and frame_err pulses once per frame.
REQ-038 rst asserted after 10 bits of a write -> all outputs 0; the next full write to address 1 <- 0x3C commits correctly.
REQ-039 NUM_REGS=4, DATA_W=16, ADDR_W=3: write 0x2 <- 0xBEEF (20-bit frame) -> regs_q[47:32] = 0xBEEF.
